// File: rtl/gray_pkg.sv
// gray_pkg: shared width, FSM states and binary increment for Gray encode/decode pairs
package gray_pkg;
  localparam int GRAY_W = 3;
  typedef enum logic {ST_SYNC, ST_TRACK} state_t;
  function automatic logic [31:0] gray_next_bin(input logic [31:0] bin, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (bin + 32'd1) & mask;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter, each bit is the XOR of all Gray bits at or above it
module gray2bin #(
  parameter int W = 3
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end
endmodule

// File: rtl/gray_decoder.sv
// gray_decoder: decodes a Gray count stream, checks single-step advance, flags errors and counts wraps
module gray_decoder
  import gray_pkg::*;
#(
  parameter int W     = GRAY_W,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_valid,
  input  logic [W-1:0]     Gray_in,
  output logic [W-1:0]     Bin_out,
  output logic             Bin_valid,
  output logic             Step_err,
  output logic             Wrap,
  output logic [CNT_W-1:0] Wrap_count
);
  state_t state, state_n;
  logic [W-1:0] bin, prev_bin, exp_bin;
  logic bad, wrapped;
  gray2bin #(.W(W)) u_g2b (.g(Gray_in), .b(bin));
  assign exp_bin = W'(gray_next_bin(32'(prev_bin), W));
  assign Bin_out = prev_bin;
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_SYNC;
    else state <= state_n;
  end
  // The first sample after reset only sets the reference; every later one is step-checked
  always_comb begin
    state_n = state;
    bad     = 1'b0;
    wrapped = 1'b0;
    if (In_valid) begin
      state_n = ST_TRACK;
      bad     = state == ST_TRACK && bin != prev_bin && bin != exp_bin;
      wrapped = state == ST_TRACK && bin == exp_bin && prev_bin == '1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_bin   <= '0;
      Bin_valid  <= 1'b0;
      Step_err   <= 1'b0;
      Wrap       <= 1'b0;
      Wrap_count <= '0;
    end else begin
      Bin_valid <= In_valid;
      if (In_valid) prev_bin <= bin;
      if (bad) Step_err <= 1'b1;
      if (wrapped) begin
        Wrap <= 1'b1;
        if (Wrap_count != '1) Wrap_count <= Wrap_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: directed vector table, saturation sequence and randomized model comparison
module tb_gray_decoder;
  localparam int W = 3;
  localparam int CNT_W = 2;
  localparam int N = 1 << W;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic In_valid = 1'b0;
  logic [W-1:0] Gray_in = '0;
  logic [W-1:0] Bin_out;
  logic Bin_valid, Step_err, Wrap;
  logic [CNT_W-1:0] Wrap_count;
  int checks = 0;
  int failures = 0;
  gray_decoder #(.W(W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .Gray_in(Gray_in),
    .Bin_out(Bin_out), .Bin_valid(Bin_valid), .Step_err(Step_err),
    .Wrap(Wrap), .Wrap_count(Wrap_count)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic rst, v;
    logic [W-1:0] g, bin;
    logic valid, err, wrap;
    logic [CNT_W-1:0] cnt;
  } vec_t;
  vec_t tbl[$];
  int m_bin, m_cnt;
  logic m_valid, m_err, m_wrap, m_sync;
  function automatic vec_t mk(logic rst, logic v, logic [W-1:0] g, logic [W-1:0] bin,
                              logic valid, logic err, logic wrap, logic [CNT_W-1:0] cnt);
    vec_t t;
    t.rst = rst; t.v = v; t.g = g; t.bin = bin;
    t.valid = valid; t.err = err; t.wrap = wrap; t.cnt = cnt;
    return t;
  endfunction
  function automatic logic [W-1:0] to_gray(int b);
    return W'(b ^ (b >> 1));
  endfunction
  function automatic int from_gray(logic [W-1:0] g);
    int b = int'(g);
    for (int s = 1; s < W; s++) b = b ^ (int'(g) >> s);
    return b;
  endfunction
  task automatic apply(logic rst, logic v, logic [W-1:0] g);
    Reset = rst;
    In_valid = v;
    Gray_in = g;
    @(posedge Clk);
    #1;
  endtask
  task automatic cmp(string nm, int idx, logic [W-1:0] eb, logic ev, logic ee, logic ew, logic [CNT_W-1:0] ec);
    checks++;
    if ({Bin_out, Bin_valid, Step_err, Wrap, Wrap_count} !== {eb, ev, ee, ew, ec}) begin
      failures++;
      $display("FAIL %s[%0d]: got bin=%0d valid=%b err=%b wrap=%b cnt=%0d, expected bin=%0d valid=%b err=%b wrap=%b cnt=%0d",
               nm, idx, Bin_out, Bin_valid, Step_err, Wrap, Wrap_count, eb, ev, ee, ew, ec);
    end
  endtask
  task automatic model_step(logic rst, logic v, logic [W-1:0] g);
    int b;
    if (rst) begin
      m_bin = 0; m_valid = 0; m_err = 0; m_wrap = 0; m_cnt = 0; m_sync = 0;
    end else begin
      m_valid = v;
      if (v) begin
        b = from_gray(g);
        if (m_sync && b != m_bin) begin
          if (b == (m_bin + 1) % N) begin
            if (b == 0) begin
              m_wrap = 1;
              if (m_cnt < CMAX) m_cnt++;
            end
          end else m_err = 1;
        end
        m_sync = 1;
        m_bin = b;
      end
    end
  endtask
  initial begin
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, to_gray(i), W'(i), 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b000, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 3'b000, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 3'b011, 2, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 3'b010, 3, 1, 1, 1, 1));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b111, 5, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b111, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b110, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b011, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b110, 4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b101, 6, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'b010, 6, 0, 1, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].g);
      cmp("vec", i, tbl[i].bin, tbl[i].valid, tbl[i].err, tbl[i].wrap, tbl[i].cnt);
    end
    apply(1, 0, '0);
    apply(0, 1, 3'b000);
    cmp("sat_sync", 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 1; i <= N; i++) begin
        int ec;
        apply(0, 1, to_gray(i % N));
        ec = k + (i == N ? 1 : 0);
        if (ec > CMAX) ec = CMAX;
        cmp("sat", k * N + i, W'(i % N), 1, 0, k > 0 || i == N, CNT_W'(ec));
      end
    end
    apply(1, 0, '0);
    model_step(1, 0, '0);
    for (int n = 0; n < 400; n++) begin
      logic r, v;
      logic [W-1:0] g;
      int sel;
      r = $urandom_range(0, 49) == 0;
      v = $urandom_range(0, 9) < 7;
      sel = $urandom_range(0, 9);
      g = sel < 6 ? to_gray((m_bin + 1) % N) : sel < 8 ? to_gray(m_bin) : W'($urandom_range(0, N - 1));
      apply(r, v, g);
      model_step(r, v, g);
      cmp("rand", n, W'(m_bin), m_valid, m_err, m_wrap, CNT_W'(m_cnt));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
